// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard interface: decoded ID instruction fields in, interlock controls out.
interface hazard_scoreboard_if #(
   parameter int unsigned REG_AW = 5
);
   logic              id_valid;
   logic              flush_id;
   logic [REG_AW-1:0] rs_id;
   logic [REG_AW-1:0] rt_id;
   logic              rs_used;
   logic              rt_used;
   logic              jr_id;
   logic [REG_AW-1:0] rd_id;
   logic              wr_id;
   logic              load_id;
   logic              mul_id;
   logic              stall;
   logic              bubble_ex;
   logic              busy;

   modport master (
      output id_valid, flush_id, rs_id, rt_id, rs_used, rt_used,
             jr_id, rd_id, wr_id, load_id, mul_id,
      input  stall, bubble_ex, busy
   );

   modport slave (
      input  id_valid, flush_id, rs_id, rt_id, rs_used, rt_used,
             jr_id, rd_id, wr_id, load_id, mul_id,
      output stall, bubble_ex, busy
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard producing the load/multiply/JR interlock and
// the structural stall for a blocking multiplier.
module hazard_scoreboard #(
   parameter int unsigned REG_AW        = 5,
   parameter int unsigned LOAD_LAT      = 1,
   parameter int unsigned MUL_LAT       = 3,
   parameter int unsigned JR_EXTRA      = 1,
   parameter int unsigned MUL_PIPELINED = 0
) (
   input  logic                clk,
   input  logic                reset,
   hazard_scoreboard_if.slave  sb
);

   localparam int unsigned NREG    = 2 ** REG_AW;
   localparam int unsigned MAX_LAT = (LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT;
   localparam int unsigned CW      = $clog2(MAX_LAT + JR_EXTRA + 1);

   localparam logic [CW-1:0] LOAD_INIT = CW'(LOAD_LAT + JR_EXTRA);
   localparam logic [CW-1:0] MUL_INIT  = CW'(MUL_LAT + JR_EXTRA);
   localparam logic [CW-1:0] MUL_BUSY  = CW'(MUL_LAT - 1);
   localparam logic [CW-1:0] JR_SLACK  = CW'(JR_EXTRA);
   localparam logic [CW-1:0] ONE       = CW'(1);

   // Register 0 is never tracked, so the array starts at 1.
   logic [CW-1:0] cnt_q [1:NREG-1];
   logic [CW-1:0] cnt_d [1:NREG-1];
   logic [CW-1:0] mul_cnt_q;
   logic [CW-1:0] mul_cnt_d;

   logic [CW-1:0] rs_cnt;
   logic [CW-1:0] rt_cnt;
   logic          haz_rs;
   logic          haz_rt;
   logic          haz_jr;
   logic          haz_mul;
   logic          any_nz;
   logic          stall_c;
   logic          issue;

   // Source lookups against pre-update state; register 0 reads as "ready".
   always_comb begin
      rs_cnt = '0;
      rt_cnt = '0;
      if (sb.rs_id != '0) rs_cnt = cnt_q[sb.rs_id];
      if (sb.rt_id != '0) rt_cnt = cnt_q[sb.rt_id];
   end

   // Hazard detection; normal consumers tolerate JR_EXTRA remaining cycles.
   always_comb begin
      haz_rs  = sb.rs_used && (sb.rs_id != '0) && (rs_cnt > JR_SLACK);
      haz_rt  = sb.rt_used && (sb.rt_id != '0) && (rt_cnt > JR_SLACK);
      haz_jr  = sb.jr_id   && (sb.rs_id != '0) && (rs_cnt != '0);
      haz_mul = 1'b0;
      if (MUL_PIPELINED == 0) haz_mul = sb.mul_id && (mul_cnt_q != '0);
      stall_c = !reset && sb.id_valid && !sb.flush_id &&
                (haz_rs || haz_rt || haz_jr || haz_mul);
      issue   = sb.id_valid && !sb.flush_id && !stall_c;
   end

   always_comb begin
      any_nz = (mul_cnt_q != '0);
      for (int unsigned r = 1; r < NREG; r++) begin
         any_nz = any_nz || (cnt_q[REG_AW'(r)] != '0);
      end
   end

   assign sb.stall     = stall_c;
   assign sb.bubble_ex = stall_c;
   assign sb.busy      = !reset && sb.id_valid && any_nz;

   // Next state: saturating decrement, then an issuing writer overrides its rd.
   always_comb begin
      for (int unsigned r = 1; r < NREG; r++) begin
         cnt_d[REG_AW'(r)] = (cnt_q[REG_AW'(r)] != '0) ? (cnt_q[REG_AW'(r)] - ONE) : '0;
      end
      mul_cnt_d = (mul_cnt_q != '0) ? (mul_cnt_q - ONE) : '0;

      if (issue && sb.wr_id && (sb.rd_id != '0)) begin
         if (sb.load_id)     cnt_d[sb.rd_id] = LOAD_INIT;
         else if (sb.mul_id) cnt_d[sb.rd_id] = MUL_INIT;
         else                cnt_d[sb.rd_id] = '0;
      end

      if ((MUL_PIPELINED == 0) && issue && sb.mul_id) mul_cnt_d = MUL_BUSY;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned r = 1; r < NREG; r++) cnt_q[REG_AW'(r)] <= '0;
         mul_cnt_q <= '0;
      end else begin
         for (int unsigned r = 1; r < NREG; r++) cnt_q[REG_AW'(r)] <= cnt_d[REG_AW'(r)];
         mul_cnt_q <= mul_cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: three parameterisations driven in lockstep.
module tb_hazard_scoreboard;

   logic clk;
   logic rst;

   logic       id_valid, flush_id, rs_used, rt_used, jr_id, wr_id, load_id, mul_id;
   logic [4:0] rs_id, rt_id, rd_id;

   int checks;
   int failures;

   // a: defaults; b: LOAD_LAT=2; c: JR_EXTRA=0 with a pipelined multiplier.
   hazard_scoreboard_if #(.REG_AW(5)) if_a ();
   hazard_scoreboard_if #(.REG_AW(5)) if_b ();
   hazard_scoreboard_if #(.REG_AW(5)) if_c ();

   assign if_a.id_valid = id_valid; assign if_b.id_valid = id_valid; assign if_c.id_valid = id_valid;
   assign if_a.flush_id = flush_id; assign if_b.flush_id = flush_id; assign if_c.flush_id = flush_id;
   assign if_a.rs_id    = rs_id;    assign if_b.rs_id    = rs_id;    assign if_c.rs_id    = rs_id;
   assign if_a.rt_id    = rt_id;    assign if_b.rt_id    = rt_id;    assign if_c.rt_id    = rt_id;
   assign if_a.rs_used  = rs_used;  assign if_b.rs_used  = rs_used;  assign if_c.rs_used  = rs_used;
   assign if_a.rt_used  = rt_used;  assign if_b.rt_used  = rt_used;  assign if_c.rt_used  = rt_used;
   assign if_a.jr_id    = jr_id;    assign if_b.jr_id    = jr_id;    assign if_c.jr_id    = jr_id;
   assign if_a.rd_id    = rd_id;    assign if_b.rd_id    = rd_id;    assign if_c.rd_id    = rd_id;
   assign if_a.wr_id    = wr_id;    assign if_b.wr_id    = wr_id;    assign if_c.wr_id    = wr_id;
   assign if_a.load_id  = load_id;  assign if_b.load_id  = load_id;  assign if_c.load_id  = load_id;
   assign if_a.mul_id   = mul_id;   assign if_b.mul_id   = mul_id;   assign if_c.mul_id   = mul_id;

   hazard_scoreboard u_a (.clk(clk), .reset(rst), .sb(if_a));
   hazard_scoreboard #(.LOAD_LAT(2)) u_b (.clk(clk), .reset(rst), .sb(if_b));
   hazard_scoreboard #(.JR_EXTRA(0), .MUL_PIPELINED(1)) u_c (.clk(clk), .reset(rst), .sb(if_c));

   logic [2:0] st, bb, bz;
   assign st = {if_c.stall,     if_b.stall,     if_a.stall};
   assign bb = {if_c.bubble_ex, if_b.bubble_ex, if_a.bubble_ex};
   assign bz = {if_c.busy,      if_b.busy,      if_a.busy};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      id_valid = 0; flush_id = 0; rs_id = 0; rt_id = 0; rs_used = 0; rt_used = 0;
      jr_id = 0; rd_id = 0; wr_id = 0; load_id = 0; mul_id = 0;
   endtask

   task automatic set_instr(input logic [4:0] rs_i, input logic rsu_i,
                            input logic [4:0] rt_i, input logic rtu_i, input logic jr_i,
                            input logic [4:0] rd_i, input logic wr_i,
                            input logic ld_i, input logic mul_i);
      id_valid = 1; flush_id = 0;
      rs_id = rs_i; rs_used = rsu_i; rt_id = rt_i; rt_used = rtu_i; jr_id = jr_i;
      rd_id = rd_i; wr_id = wr_i; load_id = ld_i; mul_id = mul_i;
   endtask

   task automatic drain();
      set_idle();
      repeat (8) cyc();
   endtask

   // Count leading stall/bubble cycles of the held ID instruction in each DUT.
   task automatic measure(input string tag, input int ea, input int eb, input int ec);
      int ns [3];
      int nb [3];
      bit done [3];
      for (int k = 0; k < 3; k++) begin ns[k] = 0; nb[k] = 0; done[k] = 0; end
      for (int cycle = 0; cycle < 8; cycle++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (!done[k]) begin
               if (st[k]) ns[k]++; else done[k] = 1;
               if (bb[k]) nb[k]++;
            end
         end
         if (done[0] && done[1] && done[2]) break;
         cyc();
      end
      check_eq({tag, "_stall_a"}, ns[0], ea);
      check_eq({tag, "_stall_b"}, ns[1], eb);
      check_eq({tag, "_stall_c"}, ns[2], ec);
      check_eq({tag, "_bubble_a"}, nb[0], ea);
      check_eq({tag, "_bubble_b"}, nb[1], eb);
      check_eq({tag, "_bubble_c"}, nb[2], ec);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      set_idle();
      rst = 1'b1;
      repeat (2) cyc();
      // A would-be hazard during reset must not stall or report busy.
      set_instr(5'd5, 1, 5'd1, 1, 0, 5'd6, 1, 0, 0);
      #1;
      check_eq("reset_stall", int'(st), 0);
      check_eq("reset_busy", int'(bz), 0);
      cyc();
      rst = 1'b0;
      @(negedge clk);
      check_eq("post_reset_stall", int'(st), 0);
      check_eq("post_reset_busy", int'(bz), 0);
      drain();

      // Load-use: load r5 then add r6,r5,r1.
      set_instr(5'd2, 1, 5'd0, 0, 0, 5'd5, 1, 1, 0); cyc();
      set_instr(5'd5, 1, 5'd1, 1, 0, 5'd6, 1, 0, 0);
      #1;
      check_eq("load_use_busy", int'(bz), 7);
      measure("load_use", 1, 2, 1);
      drain();

      // Load r8 then jr r8.
      set_instr(5'd2, 1, 5'd0, 0, 0, 5'd8, 1, 1, 0); cyc();
      set_instr(5'd8, 1, 5'd0, 0, 1, 5'd0, 0, 0, 0);
      measure("jr_load", 2, 3, 1);
      drain();

      // Back-to-back independent muls.
      set_instr(5'd1, 1, 5'd2, 1, 0, 5'd3, 1, 0, 1); cyc();
      set_instr(5'd1, 1, 5'd2, 1, 0, 5'd4, 1, 0, 1);
      measure("mul_mul", 2, 2, 0);
      drain();

      // ALU consumer of a mul result.
      set_instr(5'd1, 1, 5'd2, 1, 0, 5'd3, 1, 0, 1); cyc();
      set_instr(5'd3, 1, 5'd0, 1, 0, 5'd6, 1, 0, 0);
      measure("mul_use", 3, 3, 3);
      drain();

      // Load into r0 is never tracked.
      set_instr(5'd2, 1, 5'd0, 0, 0, 5'd0, 1, 1, 0); cyc();
      set_instr(5'd0, 1, 5'd0, 1, 0, 5'd6, 1, 0, 0);
      measure("r0_use", 0, 0, 0);
      drain();

      // Flushed load of r7 leaves r7 untracked.
      set_instr(5'd2, 1, 5'd0, 0, 0, 5'd7, 1, 1, 0);
      flush_id = 1;
      cyc();
      set_instr(5'd7, 1, 5'd0, 0, 0, 5'd6, 1, 0, 0);
      #1;
      check_eq("flush_busy", int'(bz), 0);
      measure("flush_use", 0, 0, 0);
      drain();

      // WAW: load r9, ALU write r9 next cycle, then consumer of r9.
      set_instr(5'd2, 1, 5'd0, 0, 0, 5'd9, 1, 1, 0); cyc();
      set_instr(5'd1, 1, 5'd2, 1, 0, 5'd9, 1, 0, 0);
      #1;
      check_eq("waw_alu_stall", int'(st), 0);
      cyc();
      set_instr(5'd9, 1, 5'd1, 1, 0, 5'd6, 1, 0, 0);
      measure("waw_use", 0, 0, 0);
      drain();

      // Reload of a counting register wins over its decrement.
      set_instr(5'd2, 1, 5'd0, 0, 0, 5'd9, 1, 1, 0); cyc();
      set_instr(5'd2, 1, 5'd0, 0, 0, 5'd9, 1, 1, 0); cyc();
      set_instr(5'd9, 1, 5'd0, 0, 0, 5'd6, 1, 0, 0);
      measure("reload_use", 1, 2, 1);
      drain();

      // Invalid or flushed consumers never stall.
      set_instr(5'd2, 1, 5'd0, 0, 0, 5'd5, 1, 1, 0); cyc();
      set_instr(5'd5, 1, 5'd5, 1, 0, 5'd6, 1, 0, 0);
      id_valid = 0;
      #1;
      check_eq("invalid_stall", int'(st), 0);
      check_eq("invalid_busy", int'(bz), 0);
      id_valid = 1;
      flush_id = 1;
      #1;
      check_eq("flushed_stall", int'(st), 0);
      flush_id = 0;
      #1;
      check_eq("unflushed_stall", int'(st), 7);
      drain();

      // Reset asserted mid-stall drops stall and busy without a clock.
      set_instr(5'd1, 1, 5'd2, 1, 0, 5'd3, 1, 0, 1); cyc();
      set_instr(5'd3, 1, 5'd1, 1, 0, 5'd6, 1, 0, 0);
      @(negedge clk);
      check_eq("pre_reset_stall", int'(st), 7);
      #1;
      rst = 1'b1;
      #1;
      check_eq("mid_reset_stall", int'(st), 0);
      check_eq("mid_reset_bubble", int'(bb), 0);
      check_eq("mid_reset_busy", int'(bz), 0);
      cyc();
      rst = 1'b0;
      @(negedge clk);
      check_eq("after_reset_stall", int'(st), 0);
      check_eq("after_reset_busy", int'(bz), 0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
